// File: rtl/srl_chain_reader.sv
// Non-destructive readout controller for a cascaded SRLC32E chain: sweeps the tail
// stage address to capture a word, then rotates the chain by 32 so it ends restored.
module srl_chain_reader #(
    parameter int N_STAGES = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        USER_CE,
    input  logic        USER_D,
    input  logic [4:0]  USER_A,
    output logic        SRL_CE,
    output logic        SRL_D,
    output logic [4:0]  SRL_A,
    input  logic        SRL_Q,
    input  logic        SRL_Q31_TAIL,
    output logic [31:0] WORD,
    output logic [2:0]  WORD_INDEX,
    output logic        WORD_VALID,
    input  logic        WORD_READY,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWEEP  = 3'd1,
        ST_EMIT   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Compared before the increment so a full 8-stage chain works with a 3-bit counter.
    localparam logic [2:0] LAST_WORD = 3'(N_STAGES - 1);

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  addr_r;
    logic [4:0]  addr_s;
    logic [4:0]  shift_r;
    logic [4:0]  shift_s;
    logic [2:0]  word_cnt_r;
    logic [2:0]  word_cnt_s;
    logic [31:0] word_r;
    logic [31:0] word_s;
    logic        busy_r;
    logic        done_r;
    logic        valid_r;

    // Next-state, counter and captured-word logic.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        shift_s    = shift_r;
        word_cnt_s = word_cnt_r;
        word_s     = word_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_s    = ST_SWEEP;
                    addr_s     = 5'd0;
                    word_cnt_s = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                word_s[addr_r] = SRL_Q;
                addr_s         = addr_r + 5'd1;
                if (addr_r == 5'd31) begin
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_SWEEP;
                end
            end
            ST_EMIT: begin
                if (WORD_READY) begin
                    state_s = ST_SHIFT;
                    shift_s = 5'd0;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_SHIFT: begin
                shift_s = shift_r + 5'd1;
                if (shift_r == 5'd31) begin
                    word_cnt_s = word_cnt_r + 3'd1;
                    if (word_cnt_r == LAST_WORD) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_SWEEP;
                        addr_s  = 5'd0;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, captured word and status flags; flags are decoded from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            addr_r     <= 5'd0;
            shift_r    <= 5'd0;
            word_cnt_r <= 3'd0;
            word_r     <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            addr_r     <= addr_s;
            shift_r    <= shift_s;
            word_cnt_r <= word_cnt_s;
            word_r     <= word_s;
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_FINISH);
            valid_r    <= (state_s == ST_EMIT);
        end
    end

    // Chain control mux: writer owns the chain only while idle.
    always_comb begin
        SRL_CE = 1'b0;
        SRL_D  = 1'b0;
        SRL_A  = 5'd0;
        case (state_r)
            ST_IDLE: begin
                SRL_CE = USER_CE;
                SRL_D  = USER_D;
                SRL_A  = USER_A;
            end
            ST_SWEEP: begin
                SRL_CE = 1'b0;
                SRL_D  = 1'b0;
                SRL_A  = addr_r;
            end
            ST_SHIFT: begin
                SRL_CE = 1'b1;
                SRL_D  = SRL_Q31_TAIL;
                SRL_A  = 5'd0;
            end
            default: begin
                SRL_CE = 1'b0;
                SRL_D  = 1'b0;
                SRL_A  = 5'd0;
            end
        endcase
    end

    assign WORD       = word_r;
    assign WORD_INDEX = word_cnt_r;
    assign WORD_VALID = valid_r;
    assign BUSY       = busy_r;
    assign DONE       = done_r;

endmodule

// File: tb/tb_srl_chain_reader.sv
// Self-checking bench for srl_chain_reader: a behavioural 96-bit SRL chain plus
// an expected-word model built by rotating the loaded pattern.
module tb_srl_chain_reader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        USER_CE;
    logic        USER_D;
    logic [4:0]  USER_A;
    logic        SRL_CE;
    logic        SRL_D;
    logic [4:0]  SRL_A;
    logic        SRL_Q;
    logic        SRL_Q31_TAIL;
    logic [31:0] WORD;
    logic [2:0]  WORD_INDEX;
    logic        WORD_VALID;
    logic        WORD_READY;
    logic        BUSY;
    logic        DONE;

    int tests = 0;
    int fails = 0;

    // Behavioural chain: bit 0 is the newest, bit 95 is the tail Q31.
    logic [95:0] chain = '0;
    logic [6:0]  tail_idx_s;

    srl_chain_reader #(.N_STAGES(3)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .USER_CE(USER_CE), .USER_D(USER_D), .USER_A(USER_A),
        .SRL_CE(SRL_CE), .SRL_D(SRL_D), .SRL_A(SRL_A),
        .SRL_Q(SRL_Q), .SRL_Q31_TAIL(SRL_Q31_TAIL),
        .WORD(WORD), .WORD_INDEX(WORD_INDEX), .WORD_VALID(WORD_VALID),
        .WORD_READY(WORD_READY), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (SRL_CE) chain <= {chain[94:0], SRL_D};
    end

    assign tail_idx_s   = 7'd64 + {2'b00, SRL_A};
    assign SRL_Q        = chain[tail_idx_s];
    assign SRL_Q31_TAIL = chain[95];

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_chain(input logic [95:0] v);
        for (int i = 95; i >= 0; i--) begin
            @(negedge CLK);
            USER_CE = 1'b1;
            USER_D  = v[i];
        end
        @(negedge CLK);
        USER_CE = 1'b0;
        USER_D  = 1'b0;
        check("load", chain, v);
    endtask

    task automatic readout(input logic [95:0] v, input int stall_word, input int stall_n, input bit poke);
        logic [95:0] rot;
        logic [31:0] exp_w [3];
        int words, dones, stalls_left, done_cyc, exp_emit;
        bit prev_valid, finished;
        rot = v;
        for (int k = 0; k < 3; k++) begin
            exp_w[k] = rot[95:64];
            rot      = {rot[63:0], rot[95:64]};
        end
        words = 0; dones = 0; stalls_left = stall_n; done_cyc = -1;
        prev_valid = 1'b0; finished = 1'b0;
        @(negedge CLK);
        START      = 1'b1;
        WORD_READY = 1'b1;
        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            @(negedge CLK);
            START = poke && (cyc == 5 || cyc == 33);
            if (cyc == 1) check("busy_rise", BUSY, 1'b1);
            if (cyc <= 32) check("sweep_addr", {SRL_CE, SRL_A}, {1'b0, 5'(cyc - 1)});
            if (cyc == 50) check("shift_ctl", {SRL_CE, SRL_D, SRL_A}, {1'b1, chain[95], 5'd0});
            if (WORD_VALID) begin
                if (!prev_valid) begin
                    exp_emit = 33 + 65 * words + ((stall_word >= 0 && words > stall_word) ? stall_n : 0);
                    check("emit_cycle", cyc, exp_emit);
                    if (words < 3) begin
                        check("word_value", WORD, exp_w[words]);
                        check("word_index", WORD_INDEX, words);
                    end else begin
                        check("extra_word", words, 2);
                    end
                    words++;
                end else begin
                    check("stall_word", WORD, exp_w[(words - 1) % 3]);
                    check("stall_ce", SRL_CE, 1'b0);
                end
                if (words - 1 == stall_word && stalls_left > 0) begin
                    WORD_READY = 1'b0;
                    stalls_left--;
                end else begin
                    WORD_READY = 1'b1;
                end
            end else begin
                WORD_READY = 1'($urandom);
            end
            prev_valid = WORD_VALID;
            if (DONE) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                finished = 1'b1;
                check("busy_fall", {BUSY, DONE}, 2'b00);
            end
        end
        check("timeout", finished, 1'b1);
        check("word_count", words, 3);
        check("done_pulses", dones, 1);
        check("done_cycle", done_cyc, 196 + stall_n);
        check("restored", chain, v);
        check("word_hold", WORD, exp_w[2]);
        START      = 1'b0;
        WORD_READY = 1'b1;
    endtask

    initial begin
        logic [95:0] pat;
        RST = 1'b1; START = 1'b0; USER_CE = 1'b0; USER_D = 1'b0; USER_A = 5'd0; WORD_READY = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("reset_flags", {BUSY, DONE, WORD_VALID}, 3'b000);
        check("reset_word", WORD, 32'd0);
        check("reset_index", WORD_INDEX, 3'd0);

        // Idle pass-through with random writer activity.
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            USER_CE = 1'($urandom);
            USER_D  = 1'($urandom);
            USER_A  = 5'($urandom);
            #1;
            check("idle_pass", {BUSY, SRL_CE, SRL_D, SRL_A}, {1'b0, USER_CE, USER_D, USER_A});
        end
        USER_CE = 1'b0; USER_D = 1'b0; USER_A = 5'd0;

        pat = 96'hDEADBEEF_12345678_0F0F0F0F;
        load_chain(pat);
        readout(pat, -1, 0, 1'b0);
        readout(pat, -1, 0, 1'b0);
        readout(pat, 1, 10, 1'b0);
        readout(pat, -1, 0, 1'b1);

        pat = {$urandom, $urandom, $urandom};
        load_chain(pat);
        readout(pat, 0, 3, 1'b0);

        // Reset in the middle of word 0's shift phase.
        @(negedge CLK);
        START = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        RST     = 1'b1;
        USER_CE = 1'($urandom);
        USER_D  = 1'($urandom);
        USER_A  = 5'($urandom);
        @(negedge CLK);
        check("rst_flags", {BUSY, WORD_VALID, DONE}, 3'b000);
        check("rst_pass", {SRL_CE, SRL_D, SRL_A}, {USER_CE, USER_D, USER_A});
        RST     = 1'b0;
        USER_CE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("rst_quiet", {BUSY, SRL_CE}, 2'b00);
        end

        pat = {$urandom, $urandom, $urandom};
        load_chain(pat);
        readout(pat, 2, 4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
